// File: rtl/conv_pkg.sv
// Types and helpers shared by the convolution window generator.
package conv_pkg;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } conv_win_state_t;

    function automatic int pad_of(input int kern_size);
        return (kern_size - 1) / 2;
    endfunction

endpackage

// File: rtl/functions_pkg.sv
// Generic elaboration-time helper functions shared across blocks.
package functions_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_win_shreg.sv
// Pixel history for the window generator; presents the post-shift window.
module conv_win_shreg #(
    parameter int KERN_SIZE = 3,
    parameter int DIN_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           shift_en,
    input  logic                           clear,
    input  logic [DIN_WIDTH-1:0]           shift_in,
    output logic [KERN_SIZE*DIN_WIDTH-1:0] shifted
);

    // The oldest slot falls out on every shift, so only KERN_SIZE-1 are kept.
    if (KERN_SIZE == 1) begin : g_single
        assign shifted = shift_in;
    end else begin : g_multi
        logic [(KERN_SIZE-1)*DIN_WIDTH-1:0] hist;

        assign shifted = {shift_in, hist};

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hist <= '0;
            end else if (clear) begin
                hist <= '0;
            end else if (shift_en) begin
                hist <= shifted[KERN_SIZE*DIN_WIDTH-1:DIN_WIDTH];
            end
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Serial pixel stream to zero-padded sliding windows for conv_kernel.
module conv_window_gen
    import conv_pkg::*, functions_pkg::*;
#(
    parameter int KERN_SIZE = 3,
    parameter int DIN_WIDTH = 8,
    parameter int ROW_LEN   = 32
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      pix_vld,
    output logic                                      pix_rdy,
    input  logic signed [DIN_WIDTH-1:0]               pix,
    output logic                                      win_vld,
    output logic signed [KERN_SIZE-1:0][DIN_WIDTH-1:0] win,
    output logic                                      win_sol,
    output logic                                      win_eol
);

    localparam int PAD = pad_of(KERN_SIZE);
    localparam int CW  = (clog2(ROW_LEN) < 1) ? 1 : clog2(ROW_LEN);

    localparam logic [CW-1:0] LAST_FILL  = CW'((PAD > 0) ? PAD - 1 : 0);
    localparam logic [CW-1:0] FIRST_RUN  = CW'(PAD);
    localparam logic [CW-1:0] LAST_COL   = CW'(ROW_LEN - 1);
    localparam logic [CW-1:0] LAST_FLUSH = CW'((PAD > 0) ? PAD - 1 : 0);

    localparam conv_win_state_t START = (PAD == 0) ? RUN : FILL;

    if (KERN_SIZE < 1 || KERN_SIZE % 2 == 0) begin : g_bad_kern
        $error("conv_window_gen: KERN_SIZE must be odd and >= 1");
    end

    if (ROW_LEN <= PAD) begin : g_bad_row
        $error("conv_window_gen: ROW_LEN must exceed (KERN_SIZE-1)/2");
    end

    conv_win_state_t state, state_nx;

    logic [CW-1:0]                  cnt, cnt_nx;
    logic                           accept;
    logic                           shift_en;
    logic                           clear;
    logic [DIN_WIDTH-1:0]           shift_in;
    logic [KERN_SIZE*DIN_WIDTH-1:0] shifted;
    logic                           vld_nx;
    logic                           sol_nx;
    logic                           eol_nx;

    assign pix_rdy = reset_n && (state != FLUSH);
    assign accept  = pix_vld && pix_rdy;

    conv_win_shreg #(
        .KERN_SIZE(KERN_SIZE),
        .DIN_WIDTH(DIN_WIDTH)
    ) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .shift_en(shift_en),
        .clear   (clear),
        .shift_in(shift_in),
        .shifted (shifted)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= START;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_en = 1'b0;
        shift_in = pix;
        clear    = 1'b0;
        vld_nx   = 1'b0;
        sol_nx   = 1'b0;
        eol_nx   = 1'b0;
        unique case (state)
            FILL: begin
                if (accept) begin
                    shift_en = 1'b1;
                    cnt_nx   = cnt + 1'b1;
                    if (cnt == LAST_FILL) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    shift_en = 1'b1;
                    vld_nx   = 1'b1;
                    sol_nx   = (cnt == FIRST_RUN);
                    if (cnt == LAST_COL) begin
                        cnt_nx = '0;
                        if (PAD == 0) begin
                            eol_nx = 1'b1;
                        end else begin
                            state_nx = FLUSH;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Right-edge padding: shift zeros while input is stalled.
                shift_en = 1'b1;
                shift_in = '0;
                vld_nx   = 1'b1;
                if (cnt == LAST_FLUSH) begin
                    eol_nx   = 1'b1;
                    clear    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = START;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = START;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_vld <= 1'b0;
            win_sol <= 1'b0;
            win_eol <= 1'b0;
            win     <= '0;
        end else begin
            win_vld <= vld_nx;
            win_sol <= sol_nx;
            win_eol <= eol_nx;
            if (vld_nx) begin
                win <= shifted;
            end
        end
    end

endmodule
